// File: rtl/ext_obi_sram_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : ext_obi_sram_pkg                                                 |
// | Brief   : Constants, grant FSM state type and parameter range checks for   |
// |           the external-bus OBI SRAM responder.                             |
// | Content : ERR_RDATA      - read data returned for out-of-range accesses    |
// |           state_t        - grant FSM states {IDLE, WAIT}                   |
// |           *_ok functions - elaboration-time parameter legality checks      |
// | Rev     : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package ext_obi_sram_pkg;

  localparam logic [31:0] ERR_RDATA       = 32'hBADC_AB1E;
  localparam int unsigned MAX_WAIT_STATES = 15;
  localparam int unsigned MIN_LATENCY     = 1;
  localparam int unsigned MAX_LATENCY     = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // The wait-state counter is 4 bits wide.
  function automatic bit wait_states_ok(input int unsigned ws);
    return ws <= MAX_WAIT_STATES;
  endfunction

  function automatic bit latency_ok(input int unsigned lat);
    return (lat >= MIN_LATENCY) && (lat <= MAX_LATENCY);
  endfunction

  // Power of two, at least 4 words, and small enough that the word index
  // plus the byte offset still leaves one address bit for the range check.
  function automatic bit num_words_ok(input int unsigned n);
    return (n >= 4) && ((n & (n - 1)) == 0) && (n <= (1 << 29));
  endfunction

  function automatic bit base_addr_ok(input logic [31:0] base, input int unsigned n);
    return (base % (4 * n)) == 0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/obi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : obi_pkg                                                          |
// | Brief   : OBI request/response bus types shared by initiators and          |
// |           responders on the external bus.                                  |
// | Types   : obi_req_t  - req, we, be[3:0], addr[31:0], wdata[31:0]           |
// |           obi_resp_t - gnt, rvalid, rdata[31:0]                            |
// | Rev     : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package obi_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage
`default_nettype wire

// File: rtl/ext_obi_resp_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ext_obi_resp_pipe                                                |
// | Brief   : Fixed-latency response shift register. A response entered on    |
// |           in_valid appears on out_valid exactly LATENCY cycles later.      |
// |           Data stages only move with their valid bit, so out_data holds    |
// |           the last delivered word while out_valid is low.                  |
// | Ports   : clk         in   clock                                           |
// |           rst_n       in   asynchronous active-low reset (flushes)         |
// |           in_valid    in   response accepted this cycle                    |
// |           in_data     in   response data                                   |
// |           out_valid   out  response valid (one cycle per entry)            |
// |           out_data    out  response data, held between responses          |
// |           stage_valid out  per-stage valid bits (in-flight indication)     |
// | Rev     : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module ext_obi_resp_pipe
  import ext_obi_sram_pkg::*;
#(
  parameter int unsigned LATENCY = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [31:0]        in_data,
  output logic               out_valid,
  output logic [31:0]        out_data,
  output logic [LATENCY-1:0] stage_valid
);

  if (!latency_ok(LATENCY)) begin : g_bad_latency
    $error("ext_obi_resp_pipe: LATENCY out of range");
  end

  logic [LATENCY-1:0] r_valid;
  logic [31:0]        r_data [LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < int'(LATENCY); i++) begin
        r_data[i] <= 32'h0;
      end
    end else begin
      r_valid[0] <= in_valid;
      if (in_valid) begin
        r_data[0] <= in_data;
      end
      for (int i = 1; i < int'(LATENCY); i++) begin
        r_valid[i] <= r_valid[i-1];
        // Stage data is frozen when no response passes through it.
        if (r_valid[i-1]) begin
          r_data[i] <= r_data[i-1];
        end
      end
    end
  end

  assign out_valid   = r_valid[LATENCY-1];
  assign out_data    = r_data[LATENCY-1];
  assign stage_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/ext_obi_sram_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ext_obi_sram_responder                                           |
// | Brief   : OBI slave on the external-xbar slave port. Grants requests after |
// |           WAIT_STATES cycles, serves a local word-addressed SRAM with byte |
// |           enables, answers every accept with one rvalid LATENCY cycles     |
// |           later, and flags out-of-range accesses with a sticky error.      |
// | Ports   : clk_i        in   clock                                          |
// |           rst_ni       in   asynchronous active-low reset                  |
// |           slave_req_i  in   OBI request (req, we, be, addr, wdata)         |
// |           slave_resp_o out  OBI response (gnt, rvalid, rdata)              |
// |           err_addr_o   out  sticky out-of-range access flag                |
// |           err_clr_i    in   synchronous clear of err_addr_o                |
// |           busy_o       out  grant wait in progress or response in flight   |
// | Rev     : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module ext_obi_sram_responder
  import obi_pkg::*;
  import ext_obi_sram_pkg::*;
#(
  parameter int unsigned NUM_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned LATENCY     = 1
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  obi_req_t  slave_req_i,
  output obi_resp_t slave_resp_o,
  output logic      err_addr_o,
  input  logic      err_clr_i,
  output logic      busy_o
);

  localparam int unsigned IDX_W  = $clog2(NUM_WORDS);
  localparam logic [3:0]  WS_CNT = 4'(WAIT_STATES);

  // ---------------------------------------------------------------------------
  // Parameter legality
  // ---------------------------------------------------------------------------
  if (!num_words_ok(NUM_WORDS)) begin : g_bad_num_words
    $error("ext_obi_sram_responder: NUM_WORDS must be a power of two >= 4");
  end
  if (!base_addr_ok(BASE_ADDR, NUM_WORDS)) begin : g_bad_base_addr
    $error("ext_obi_sram_responder: BASE_ADDR must be aligned to 4*NUM_WORDS");
  end
  if (!wait_states_ok(WAIT_STATES)) begin : g_bad_wait_states
    $error("ext_obi_sram_responder: WAIT_STATES out of range");
  end

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [31:0]      w_offset;
  logic             w_in_range;
  logic [IDX_W-1:0] w_index;
  logic             w_unused_addr_lsb;

  assign w_offset = slave_req_i.addr - BASE_ADDR;
  // The lower bound is checked explicitly because the subtraction wraps for
  // addresses below the base; the upper bound is "no bits above the index".
  assign w_in_range = (slave_req_i.addr >= BASE_ADDR) &&
                      (w_offset[31:IDX_W+2] == '0);
  assign w_index    = w_offset[IDX_W+1:2];
  // Byte offset within the word is irrelevant to a word-addressed SRAM.
  assign w_unused_addr_lsb = ^w_offset[1:0];

  // ---------------------------------------------------------------------------
  // Grant FSM
  // ---------------------------------------------------------------------------
  state_t     r_state;
  logic [3:0] r_cnt;
  logic       w_gnt;
  logic       w_accept;

  // r_cnt counts the completed cycles req has been held; grant once it
  // reaches WAIT_STATES. Gated by reset so gnt is low while held in reset.
  assign w_gnt = rst_ni && slave_req_i.req &&
                 ((WAIT_STATES == 0) || ((r_state == WAIT) && (r_cnt == WS_CNT)));
  assign w_accept = slave_req_i.req && w_gnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (slave_req_i.req && (WAIT_STATES != 0)) begin
            r_state <= WAIT;
            r_cnt   <= 4'd1;
          end
        end
        WAIT: begin
          // Both an accept and a withdrawn request end the wait.
          if (!slave_req_i.req || w_gnt) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // SRAM (contents are not reset)
  // ---------------------------------------------------------------------------
  logic [31:0] r_mem [NUM_WORDS];
  logic        w_mem_we;

  assign w_mem_we = w_accept && w_in_range && slave_req_i.we;

  always_ff @(posedge clk_i) begin
    if (w_mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (slave_req_i.be[b]) begin
          r_mem[w_index][8*b +: 8] <= slave_req_i.wdata[8*b +: 8];
        end
      end
    end
  end

  // Response word captured at the accept edge. A read issued the cycle after
  // a write to the same word sees the new value because the write has
  // already landed in the array by then.
  logic [31:0] w_resp_data;

  always_comb begin
    w_resp_data = 32'h0;
    if (!w_in_range) begin
      w_resp_data = ERR_RDATA;
    end else if (!slave_req_i.we) begin
      w_resp_data = r_mem[w_index];
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky out-of-range flag: a new error wins over a same-cycle clear
  // ---------------------------------------------------------------------------
  logic r_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err <= 1'b0;
    end else if (w_accept && !w_in_range) begin
      r_err <= 1'b1;
    end else if (err_clr_i) begin
      r_err <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Response pipeline
  // ---------------------------------------------------------------------------
  logic               w_rvalid;
  logic [31:0]        w_rdata;
  logic [LATENCY-1:0] w_stage_valid;

  ext_obi_resp_pipe #(
    .LATENCY (LATENCY)
  ) u_resp_pipe (
    .clk         (clk_i),
    .rst_n       (rst_ni),
    .in_valid    (w_accept),
    .in_data     (w_resp_data),
    .out_valid   (w_rvalid),
    .out_data    (w_rdata),
    .stage_valid (w_stage_valid)
  );

  assign slave_resp_o.gnt    = w_gnt;
  assign slave_resp_o.rvalid = w_rvalid;
  assign slave_resp_o.rdata  = w_rdata;
  assign err_addr_o          = r_err;
  assign busy_o              = (r_state == WAIT) || (|w_stage_valid);

endmodule
`default_nettype wire

// File: tb/tb_ext_obi_sram_responder.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_ext_obi_sram_responder                                        |
// | Brief   : Three responder instances (no wait/lat 1, 3 waits/lat 1,         |
// |           no wait/lat 3) against a transaction-level reference model,      |
// |           plus directed vectors with literal expectations.                 |
// | Rev     : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_ext_obi_sram_responder;
  import obi_pkg::*;

  localparam int NCH = 3;
  localparam int NW  = 16;
  localparam int          WS_P   [NCH] = '{0, 3, 0};
  localparam int          LAT_P  [NCH] = '{1, 1, 3};
  localparam logic [31:0] BASE_P [NCH] = '{32'h0000_1000, 32'h0000_2000, 32'h0000_0000};

  logic      clk;
  logic      rst_n;
  obi_req_t  req_s  [NCH];
  obi_resp_t resp_s [NCH];
  logic      err_s  [NCH];
  logic      clr_s  [NCH];
  logic      busy_s [NCH];

  for (genvar g = 0; g < NCH; g++) begin : g_dut
    ext_obi_sram_responder #(
      .NUM_WORDS   (NW),
      .BASE_ADDR   (BASE_P[g]),
      .WAIT_STATES (WS_P[g]),
      .LATENCY     (LAT_P[g])
    ) u_dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .slave_req_i  (req_s[g]),
      .slave_resp_o (resp_s[g]),
      .err_addr_o   (err_s[g]),
      .err_clr_i    (clr_s[g]),
      .busy_o       (busy_s[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: each accepted request becomes a queued response due
  // LATENCY-1 cycles after the accepting edge (i.e. sampled LATENCY edges
  // later); a request is granted on its (WS+1)-th consecutive cycle.
  // ---------------------------------------------------------------------------
  typedef struct {
    int          ch;
    logic [31:0] data;
    int          due;
  } ent_t;

  ent_t        pq[$];
  logic [31:0] mem_m  [NCH][NW];
  int          run_m  [NCH];
  logic        err_m  [NCH];
  logic [31:0] last_m [NCH];
  int          cyc = 0;

  function automatic int head(input int k);
    for (int i = 0; i < pq.size(); i++) begin
      if (pq[i].ch == k) return i;
    end
    return -1;
  endfunction

  function automatic logic gnt_rule(input int k);
    return rst_n && req_s[k].req && (WS_P[k] == 0 || run_m[k] == WS_P[k]);
  endfunction

  initial begin
    for (int k = 0; k < NCH; k++) begin
      run_m[k] = 0; err_m[k] = 1'b0; last_m[k] = 32'h0;
      for (int w = 0; w < NW; w++) mem_m[k][w] = 32'h0;
    end
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        pq.delete();
        for (int k = 0; k < NCH; k++) begin
          run_m[k] = 0; err_m[k] = 1'b0; last_m[k] = 32'h0;
        end
      end else begin
        cyc++;
        for (int k = 0; k < NCH; k++) begin
          int h;
          h = head(k);
          if (h >= 0 && pq[h].due < cyc) begin
            last_m[k] = pq[h].data;
            pq.delete(h);
          end
        end
        for (int k = 0; k < NCH; k++) begin
          if (gnt_rule(k)) begin
            longint off;
            logic [31:0] d;
            int idx;
            off = longint'(req_s[k].addr) - longint'(BASE_P[k]);
            if (off < 0 || off >= longint'(4 * NW)) begin
              d = 32'hBADC_AB1E;
              err_m[k] = 1'b1;
            end else begin
              idx = int'(off >>> 2);
              if (req_s[k].we) begin
                for (int b = 0; b < 4; b++)
                  if (req_s[k].be[b]) mem_m[k][idx][8*b +: 8] = req_s[k].wdata[8*b +: 8];
                d = 32'h0;
              end else begin
                d = mem_m[k][idx];
              end
              if (clr_s[k]) err_m[k] = 1'b0;
            end
            pq.push_back('{ch: k, data: d, due: cyc + LAT_P[k] - 1});
            run_m[k] = 0;
          end else begin
            run_m[k] = req_s[k].req ? run_m[k] + 1 : 0;
            if (clr_s[k]) err_m[k] = 1'b0;
          end
        end
      end
    end
  end

  // Records, for the latency-3 instance, the edge that samples each rvalid.
  int          rv_edge[$];
  logic [31:0] rv_data[$];

  // Compare process: every output of every instance, every cycle.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < NCH; k++) begin
        int h;
        logic rv_e;
        logic [31:0] rd_e;
        h    = head(k);
        rv_e = (h >= 0) && (pq[h].due == cyc);
        rd_e = rv_e ? pq[h].data : last_m[k];
        chk1 ($sformatf("model ch%0d gnt", k),    resp_s[k].gnt,    gnt_rule(k));
        chk1 ($sformatf("model ch%0d rvalid", k), resp_s[k].rvalid, rv_e);
        chk32($sformatf("model ch%0d rdata", k),  resp_s[k].rdata,  rd_e);
        chk1 ($sformatf("model ch%0d err", k),    err_s[k],         err_m[k]);
        chk1 ($sformatf("model ch%0d busy", k),   busy_s[k],        (run_m[k] > 0) || (h >= 0));
      end
      if (resp_s[2].rvalid === 1'b1) begin
        rv_edge.push_back(cyc + 1);
        rv_data.push_back(resp_s[2].rdata);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all called just after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata);
    req_s[k].req = 1'b1; req_s[k].we = we; req_s[k].be = be;
    req_s[k].addr = addr; req_s[k].wdata = wdata;
  endtask

  task automatic idle_req(input int k);
    req_s[k] = '0;
  endtask

  // Holds a request until granted; returns the number of request cycles.
  task automatic xfer(input int k, input logic we, input logic [3:0] be,
                      input logic [31:0] addr, input logic [31:0] wdata, output int n);
    n = 0;
    set_req(k, we, be, addr, wdata);
    do begin
      @(negedge clk);
      n++;
    end while (resp_s[k].gnt !== 1'b1 && n < 40);
    chk1($sformatf("ch%0d gnt within bound", k), resp_s[k].gnt, 1'b1);
    step();
    idle_req(k);
  endtask

  int n;
  int a0;

  initial begin
    for (int k = 0; k < NCH; k++) begin
      req_s[k] = '0;
      clr_s[k] = 1'b0;
    end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NCH; k++) begin
      chk1 ($sformatf("reset ch%0d gnt", k),    resp_s[k].gnt,    1'b0);
      chk1 ($sformatf("reset ch%0d rvalid", k), resp_s[k].rvalid, 1'b0);
      chk32($sformatf("reset ch%0d rdata", k),  resp_s[k].rdata,  32'h0);
      chk1 ($sformatf("reset ch%0d err", k),    err_s[k],         1'b0);
      chk1 ($sformatf("reset ch%0d busy", k),   busy_s[k],        1'b0);
    end
    step();
    rst_n = 1'b1;
    step();

    // 1: full-word write then read, zero wait, latency 1
    xfer(0, 1'b1, 4'hF, 32'h1010, 32'hDEAD_BEEF, n);
    chk32("t1 write gnt cycles", 32'(n), 32'd1);
    @(negedge clk);
    chk1 ("t1 write rvalid", resp_s[0].rvalid, 1'b1);
    chk32("t1 write rdata", resp_s[0].rdata, 32'h0);
    step();
    xfer(0, 1'b0, 4'h0, 32'h1010, 32'h0, n);
    chk32("t1 read gnt cycles", 32'(n), 32'd1);
    @(negedge clk);
    chk1 ("t1 read rvalid", resp_s[0].rvalid, 1'b1);
    chk32("t1 read rdata", resp_s[0].rdata, 32'hDEAD_BEEF);
    step();

    // 2: partial byte-enable write, back-to-back with readback
    xfer(0, 1'b1, 4'hF, 32'h1014, 32'hAAAA_AAAA, n);
    xfer(0, 1'b1, 4'b0101, 32'h1014, 32'h1122_3344, n);
    xfer(0, 1'b0, 4'h0, 32'h1014, 32'h0, n);
    @(negedge clk);
    chk32("t2 byte-enable readback", resp_s[0].rdata, 32'hAA22_AA44);
    step();

    // 3: three wait states
    set_req(1, 1'b1, 4'hF, 32'h2000, 32'hCAFE_F00D);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk1($sformatf("t3 gnt req-cycle %0d", i + 1), resp_s[1].gnt, i == 3);
      step();
    end
    idle_req(1);
    step();
    set_req(1, 1'b0, 4'h0, 32'h2000, 32'h0);
    step();
    step();
    idle_req(1);
    @(negedge clk);
    chk1("t3 busy while dropping", busy_s[1], 1'b1);
    step();
    @(negedge clk);
    chk1("t3 busy after drop", busy_s[1], 1'b0);
    chk1("t3 gnt after drop", resp_s[1].gnt, 1'b0);
    step();
    xfer(1, 1'b0, 4'h0, 32'h2000, 32'h0, n);
    chk32("t3 read gnt cycles", 32'(n), 32'd4);
    set_req(1, 1'b0, 4'h0, 32'h2000, 32'h0);
    @(negedge clk);
    chk32("t3 read rdata", resp_s[1].rdata, 32'hCAFE_F00D);
    chk1 ("t3 no gnt on re-entry", resp_s[1].gnt, 1'b0);
    step();
    xfer(1, 1'b0, 4'h0, 32'h2000, 32'h0, n);
    chk32("t3 second read gnt cycles", 32'(n + 1), 32'd4);

    // 4: latency 3, back-to-back streams
    for (int i = 0; i < 8; i++) begin
      set_req(2, 1'b1, 4'hF, 32'(4 * i), 32'hC0DE_0000 + 32'(i));
      step();
    end
    idle_req(2);
    repeat (4) step();
    rv_edge.delete();
    rv_data.delete();
    a0 = 0;
    for (int i = 0; i < 8; i++) begin
      set_req(2, 1'b0, 4'h0, 32'(4 * i), 32'h0);
      step();
      if (i == 0) a0 = cyc;
    end
    idle_req(2);
    repeat (6) step();
    chk32("t4 rvalid count", 32'(rv_edge.size()), 32'd8);
    for (int i = 0; i < rv_edge.size(); i++) begin
      chk32($sformatf("t4 rvalid %0d edge offset", i), 32'(rv_edge[i] - a0), 32'(3 + i));
      chk32($sformatf("t4 rvalid %0d data", i), rv_data[i], 32'hC0DE_0000 + 32'(i));
    end

    // 5: out-of-range accesses and the sticky error flag
    xfer(0, 1'b1, 4'hF, 32'h103C, 32'h5555_AAAA, n);
    xfer(0, 1'b1, 4'hF, 32'h1000, 32'h0102_0304, n);
    xfer(0, 1'b0, 4'h0, 32'h1040, 32'h0, n);
    @(negedge clk);
    chk1 ("t5 oor rvalid", resp_s[0].rvalid, 1'b1);
    chk32("t5 oor rdata", resp_s[0].rdata, 32'hBADC_AB1E);
    chk1 ("t5 err set", err_s[0], 1'b1);
    step();
    clr_s[0] = 1'b1;
    xfer(0, 1'b1, 4'hF, 32'h0FFC, 32'hFFFF_FFFF, n);
    clr_s[0] = 1'b0;
    @(negedge clk);
    chk1("t5 set beats clear", err_s[0], 1'b1);
    step();
    clr_s[0] = 1'b1;
    step();
    clr_s[0] = 1'b0;
    @(negedge clk);
    chk1("t5 clear alone", err_s[0], 1'b0);
    step();
    xfer(0, 1'b0, 4'h0, 32'h103C, 32'h0, n);
    @(negedge clk);
    chk32("t5 last word intact", resp_s[0].rdata, 32'h5555_AAAA);
    step();
    xfer(0, 1'b0, 4'h0, 32'h1000, 32'h0, n);
    @(negedge clk);
    chk32("t5 first word intact", resp_s[0].rdata, 32'h0102_0304);
    step();

    // 6: reset with two responses in flight
    set_req(2, 1'b0, 4'h0, 32'h0, 32'h0);
    step();
    set_req(2, 1'b0, 4'h0, 32'h4, 32'h0);
    step();
    idle_req(2);
    rst_n = 1'b0;
    #1;
    chk1("t6 rvalid in reset", resp_s[2].rvalid, 1'b0);
    chk1("t6 busy in reset", busy_s[2], 1'b0);
    rv_edge.delete();
    repeat (2) step();
    rst_n = 1'b1;
    repeat (6) step();
    chk32("t6 no late rvalid", 32'(rv_edge.size()), 32'd0);
    xfer(2, 1'b0, 4'h0, 32'h0, 32'h0, n);
    repeat (3) @(negedge clk);
    chk1 ("t6 read rvalid", resp_s[2].rvalid, 1'b1);
    chk32("t6 data survives reset", resp_s[2].rdata, 32'hC0DE_0000);
    step();
    xfer(0, 1'b0, 4'h0, 32'h1010, 32'h0, n);
    @(negedge clk);
    chk32("t6 ch0 data survives reset", resp_s[0].rdata, 32'hDEAD_BEEF);
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
